// File: rtl/bp_be_pipe_sys_n_if.sv
// Page-table-walker bus between the system pipe (master side) and the walker (slave side).
interface bp_be_pipe_sys_n_if #(
  parameter int vaddr_width_p = 39
) ();
  logic                     ptw_miss_v_o;
  logic [1:0]               ptw_miss_type_o;
  logic [vaddr_width_p-1:0] ptw_miss_pc_o;
  logic [vaddr_width_p-1:0] ptw_miss_vaddr_o;
  logic                     ptw_fill_v_i;
  logic                     ptw_fault_i;
  logic [vaddr_width_p-1:0] ptw_fault_vaddr_i;

  modport master (
    output ptw_miss_v_o, ptw_miss_type_o, ptw_miss_pc_o, ptw_miss_vaddr_o,
    input  ptw_fill_v_i, ptw_fault_i, ptw_fault_vaddr_i
  );

  modport slave (
    input  ptw_miss_v_o, ptw_miss_type_o, ptw_miss_pc_o, ptw_miss_vaddr_o,
    output ptw_fill_v_i, ptw_fault_i, ptw_fault_vaddr_i
  );
endinterface

// File: rtl/bp_be_pipe_sys_n.sv
// Back-end system pipe: delays sys/CSR ops to commit and arbitrates TLB misses to the page walker.
// Define BP_BE_SYS_MISS_CNT_EN to build the saturating walk-request counter on miss_cnt_o.
module bp_be_pipe_sys_n #(
  parameter int vaddr_width_p = 39,
  parameter int instr_width_p = 32,
  parameter int dword_width_p = 64,
  parameter int stages_p      = 2
) (
  input  logic                     clk_i,
  input  logic                     reset_i,

  input  logic                     v_i,
  input  logic                     poison_i,
  input  logic                     sys_v_i,
  input  logic                     csr_v_i,
  input  logic                     is_store_i,
  input  logic [vaddr_width_p-1:0] pc_i,
  input  logic [instr_width_p-1:0] instr_i,
  input  logic [dword_width_p-1:0] rs1_i,
  input  logic [dword_width_p-1:0] imm_i,
  input  logic [3:0]               csr_op_i,
  input  logic                     csr_imm_i,

  input  logic                     flush_i,
  input  logic                     commit_v_i,
  input  logic                     itlb_miss_i,
  input  logic                     dtlb_miss_i,
  input  logic                     irq_pending_i,
  input  logic                     mem_ready_i,
  input  logic                     long_ready_i,

  bp_be_pipe_sys_n_if.master       ptw,

  output logic                     csr_cmd_v_o,
  output logic [3:0]               csr_op_o,
  output logic [11:0]              csr_addr_o,
  output logic [dword_width_p-1:0] csr_data_o,
  output logic                     v_o,
  output logic                     ready_o,
  output logic                     interrupt_v_o,
  output logic                     replay_o,
  output logic                     fault_v_o,
  output logic [1:0]               fault_type_o,
  output logic [vaddr_width_p-1:0] fault_vaddr_o,
  output logic [15:0]              miss_cnt_o
);

  typedef enum logic [1:0] {
    e_idle = 2'd0,
    e_miss = 2'd1,
    e_wait = 2'd2
  } state_e;

  typedef struct packed {
    logic [vaddr_width_p-1:0] pc;
    logic [instr_width_p-1:0] instr;
    logic                     store;
    logic [vaddr_width_p-1:0] vaddr;
    logic [3:0]               csr_op;
    logic [11:0]              csr_addr;
    logic [dword_width_p-1:0] csr_data;
  } stage_s;

  logic [dword_width_p-1:0] eff_addr;
  stage_s                   dispatch;
  stage_s                   commit;
  stage_s                   data_r [stages_p];
  logic [stages_p-1:0]      sys_v_r;
  logic [stages_p-1:0]      csr_v_r;

  state_e                   state_r, state_n;
  logic                     miss_req;
  logic                     take_miss;
  logic                     fault_hit;
  logic [1:0]               miss_type_r;
  logic [vaddr_width_p-1:0] miss_pc_r;
  logic [vaddr_width_p-1:0] miss_vaddr_r;
  logic                     fault_v_r;
  logic                     unused_bits;

  assign eff_addr = rs1_i + imm_i;

  assign dispatch = '{
    pc:       pc_i,
    instr:    instr_i,
    store:    is_store_i,
    vaddr:    eff_addr[vaddr_width_p-1:0],
    csr_op:   csr_op_i,
    csr_addr: instr_i[31:20],
    csr_data: csr_imm_i ? imm_i : rs1_i
  };

  // Flush also blocks the op dispatching in the same cycle, so nothing older than the flush survives.
  // NOTE: sequential state uses <= so each stage samples its neighbour's pre-edge value.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      sys_v_r <= '0;
      csr_v_r <= '0;
    end else if (flush_i) begin
      sys_v_r <= '0;
      csr_v_r <= '0;
    end else begin
      sys_v_r[0] <= v_i & ~poison_i & sys_v_i;
      csr_v_r[0] <= v_i & ~poison_i & csr_v_i;
      for (int i = 1; i < stages_p; i++) begin
        sys_v_r[i] <= sys_v_r[i-1];
        csr_v_r[i] <= csr_v_r[i-1];
      end
    end
  end

  // NOTE: payload flops have no reset; valid bits and the FSM decide when their contents matter.
  always_ff @(posedge clk_i) begin
    data_r[0] <= dispatch;
    for (int i = 1; i < stages_p; i++) begin
      data_r[i] <= data_r[i-1];
    end
  end

  assign commit = data_r[stages_p-1];

  assign v_o         = sys_v_r[stages_p-1];
  assign csr_cmd_v_o = csr_v_r[stages_p-1] & commit_v_i;
  assign csr_op_o    = commit.csr_op;
  assign csr_addr_o  = commit.csr_addr;
  assign csr_data_o  = commit.csr_data;

  assign miss_req = commit_v_i & (itlb_miss_i | dtlb_miss_i);

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) state_r <= e_idle;
    else         state_r <= state_n;
  end

  // Misses arriving while a walk is outstanding are bounced back as replays.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    state_n   = state_r;
    take_miss = 1'b0;
    fault_hit = 1'b0;
    replay_o  = 1'b0;
    unique case (state_r)
      e_idle: begin
        if (miss_req) begin
          state_n   = e_miss;
          take_miss = 1'b1;
        end
      end
      e_miss: begin
        state_n  = e_wait;
        replay_o = miss_req;
      end
      e_wait: begin
        replay_o = miss_req;
        if (ptw.ptw_fill_v_i) begin
          state_n   = e_idle;
          fault_hit = ptw.ptw_fault_i;
        end
      end
      default: state_n = e_idle;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (take_miss) begin
      miss_type_r  <= itlb_miss_i ? 2'b01 : (commit.store ? 2'b11 : 2'b10);
      miss_pc_r    <= commit.pc;
      miss_vaddr_r <= itlb_miss_i ? commit.pc : commit.vaddr;
    end
    if (fault_hit) begin
      fault_type_o  <= miss_type_r;
      fault_vaddr_o <= ptw.ptw_fault_vaddr_i;
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) fault_v_r <= 1'b0;
    else         fault_v_r <= fault_hit;
  end

  assign fault_v_o            = fault_v_r;
  assign ptw.ptw_miss_v_o     = (state_r == e_miss);
  assign ptw.ptw_miss_type_o  = miss_type_r;
  assign ptw.ptw_miss_pc_o    = miss_pc_r;
  assign ptw.ptw_miss_vaddr_o = miss_vaddr_r;

  assign ready_o       = ~irq_pending_i & (state_r == e_idle);
  assign interrupt_v_o = irq_pending_i & mem_ready_i & long_ready_i & ~commit_v_i
                       & (state_r == e_idle) & ~(|sys_v_r);

`ifdef BP_BE_SYS_MISS_CNT_EN
  logic [15:0] miss_cnt_r;

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i)                                           miss_cnt_r <= '0;
    else if ((state_r == e_miss) && (miss_cnt_r != 16'hFFFF)) miss_cnt_r <= miss_cnt_r + 16'd1;
  end

  assign miss_cnt_o = miss_cnt_r;
`else
  assign miss_cnt_o = '0;
`endif

  // Committed instruction word and the high address bits are carried but never consumed here.
  assign unused_bits = ^{commit.instr, eff_addr[dword_width_p-1:vaddr_width_p]};

endmodule

// File: tb/tb_bp_be_pipe_sys_n.sv
// Scoreboard bench for bp_be_pipe_sys_n: a per-cycle reference model queues expected events, a negedge monitor retires them.
module tb_bp_be_pipe_sys_n;
  localparam int VA   = 39;
  localparam int IW   = 32;
  localparam int DW   = 64;
  localparam int ST   = 2;
  localparam int MAXC = 4096;

  localparam int CH_V = 0, CH_CSR = 1, CH_MISS = 2, CH_FAULT = 3, CH_REPLAY = 4, NCH = 5;

  typedef struct {
    bit            reset, v, poison, sys, csr, store, csr_imm, flush;
    bit            commit, itlb, dtlb, irq, mem_rdy, long_rdy, fill, fault;
    logic [VA-1:0] pc, fault_vaddr;
    logic [IW-1:0] instr;
    logic [DW-1:0] rs1, imm;
    logic [3:0]    op;
  } stim_t;

  typedef struct {
    int           t;
    logic [127:0] data;
  } ev_t;

  typedef struct {
    int          t;
    logic        ready, intr;
    logic [15:0] cnt;
  } lvl_t;

  logic clk;
  logic reset_i;
  logic v_i, poison_i, sys_v_i, csr_v_i, is_store_i, csr_imm_i;
  logic [VA-1:0] pc_i;
  logic [IW-1:0] instr_i;
  logic [DW-1:0] rs1_i, imm_i;
  logic [3:0]    csr_op_i;
  logic flush_i, commit_v_i, itlb_miss_i, dtlb_miss_i, irq_pending_i, mem_ready_i, long_ready_i;
  logic          csr_cmd_v_o, v_o, ready_o, interrupt_v_o, replay_o, fault_v_o;
  logic [3:0]    csr_op_o;
  logic [11:0]   csr_addr_o;
  logic [DW-1:0] csr_data_o;
  logic [1:0]    fault_type_o;
  logic [VA-1:0] fault_vaddr_o;
  logic [15:0]   miss_cnt_o;

  bp_be_pipe_sys_n_if #(.vaddr_width_p(VA)) ptw_if ();

  bp_be_pipe_sys_n #(
    .vaddr_width_p(VA), .instr_width_p(IW), .dword_width_p(DW), .stages_p(ST)
  ) dut (
    .clk_i(clk), .reset_i(reset_i),
    .v_i(v_i), .poison_i(poison_i), .sys_v_i(sys_v_i), .csr_v_i(csr_v_i), .is_store_i(is_store_i),
    .pc_i(pc_i), .instr_i(instr_i), .rs1_i(rs1_i), .imm_i(imm_i), .csr_op_i(csr_op_i), .csr_imm_i(csr_imm_i),
    .flush_i(flush_i), .commit_v_i(commit_v_i), .itlb_miss_i(itlb_miss_i), .dtlb_miss_i(dtlb_miss_i),
    .irq_pending_i(irq_pending_i), .mem_ready_i(mem_ready_i), .long_ready_i(long_ready_i),
    .ptw(ptw_if),
    .csr_cmd_v_o(csr_cmd_v_o), .csr_op_o(csr_op_o), .csr_addr_o(csr_addr_o), .csr_data_o(csr_data_o),
    .v_o(v_o), .ready_o(ready_o), .interrupt_v_o(interrupt_v_o), .replay_o(replay_o),
    .fault_v_o(fault_v_o), .fault_type_o(fault_type_o), .fault_vaddr_o(fault_vaddr_o),
    .miss_cnt_o(miss_cnt_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int    n_vec = 0;
  int    n_err = 0;
  int    cyc   = 0;
  bit    started = 1'b0;

  ev_t   q [NCH][$];
  lvl_t  q_lvl [$];

  // Reference-model state: per-cycle dispatch history plus the outstanding walk.
  stim_t hist [MAXC];
  bit    hsys [MAXC];
  bit    hcsr [MAXC];
  bit    kill [MAXC];
  bit    pending = 1'b0;
  int    miss_at = -1;
  logic [1:0] m_type = 2'b00;
  int    cnt = 0;
  bit    prev_miss = 1'b0;

  task automatic check(string nm, logic [127:0] act, logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s @cycle %0d: got %0h, want %0h", nm, cyc, act, exp);
    end
  endtask

  function automatic stim_t idle_stim();
    stim_t s;
    s = '{default: '0};
    s.mem_rdy  = 1'b1;
    s.long_rdy = 1'b1;
    return s;
  endfunction

  function automatic bit pct(int p);
    return ($urandom_range(99) < p);
  endfunction

  function automatic stim_t rand_stim();
    stim_t s;
    s = idle_stim();
    s.reset    = ($urandom_range(999) < 4);
    s.v        = pct(60);
    s.poison   = pct(10);
    s.sys      = pct(70);
    s.csr      = pct(40);
    s.store    = pct(50);
    s.csr_imm  = pct(50);
    s.flush    = pct(8);
    s.commit   = pct(50);
    s.itlb     = pct(8);
    s.dtlb     = pct(15);
    s.irq      = pct(30);
    s.mem_rdy  = pct(85);
    s.long_rdy = pct(85);
    s.fill     = pct(25);
    s.fault    = pct(50);
    s.pc          = VA'({$urandom(), $urandom()});
    s.fault_vaddr = VA'({$urandom(), $urandom()});
    s.instr       = $urandom();
    s.rs1         = {$urandom(), $urandom()};
    s.imm         = {$urandom(), $urandom()};
    s.op          = 4'($urandom());
    return s;
  endfunction

  // An op issued at cycle c is still live at cycle t if nothing flushed or reset it in between.
  function automatic bit alive(int c, int t, bit want_csr);
    if (c < 1) return 1'b0;
    if (!(want_csr ? hcsr[c] : hsys[c])) return 1'b0;
    for (int k = c; k < t; k++) if (kill[k]) return 1'b0;
    return 1'b1;
  endfunction

  task automatic push_ev(int ch, int t, logic [127:0] d);
    ev_t e;
    e.t    = t;
    e.data = d;
    q[ch].push_back(e);
  endtask

  task automatic push_lvl(int t, logic rdy, logic intr, int c);
    lvl_t l;
    l.t     = t;
    l.ready = rdy;
    l.intr  = intr;
    l.cnt   = 16'(c);
    q_lvl.push_back(l);
  endtask

  task automatic model(stim_t s);
    int t, c, cc;
    bit idle, in_miss, inflight, miss_req;
    logic [1:0]    ty;
    logic [VA-1:0] va;
    logic [DW-1:0] sum, cdata;
    t  = cyc;
    c  = t - ST;
    cc = (c < 0) ? 0 : c;
    hist[t] = s;
    hsys[t] = s.v & ~s.poison & s.sys;
    hcsr[t] = s.v & ~s.poison & s.csr;
    kill[t] = s.flush | s.reset;
    if (s.reset) begin
      pending   = 1'b0;
      prev_miss = 1'b0;
      cnt       = 0;
      for (int ch = 0; ch < NCH; ch++)
        while (q[ch].size() > 0 && q[ch][q[ch].size()-1].t >= t) void'(q[ch].pop_back());
      push_lvl(t, ~s.irq, s.irq & s.mem_rdy & s.long_rdy & ~s.commit, 0);
      return;
    end
`ifdef BP_BE_SYS_MISS_CNT_EN
    if (prev_miss && cnt < 65535) cnt++;
`endif
    idle     = !pending;
    in_miss  = pending && (t == miss_at);
    inflight = 1'b0;
    for (int d = 1; d <= ST; d++) if (alive(t - d, t, 1'b0)) inflight = 1'b1;
    if (alive(c, t, 1'b0)) push_ev(CH_V, t, '0);
    if (s.commit && alive(c, t, 1'b1)) begin
      cdata = hist[cc].csr_imm ? hist[cc].imm : hist[cc].rs1;
      push_ev(CH_CSR, t, 128'({hist[cc].op, hist[cc].instr[31:20], cdata}));
    end
    miss_req = s.commit & (s.itlb | s.dtlb);
    if (miss_req && idle) begin
      sum = hist[cc].rs1 + hist[cc].imm;
      ty  = s.itlb ? 2'b01 : (hist[cc].store ? 2'b11 : 2'b10);
      va  = s.itlb ? hist[cc].pc : sum[VA-1:0];
      pending = 1'b1;
      miss_at = t + 1;
      m_type  = ty;
      push_ev(CH_MISS, t + 1, 128'({ty, hist[cc].pc, va}));
    end else if (miss_req) begin
      push_ev(CH_REPLAY, t, '0);
    end
    if (!idle && !in_miss && s.fill) begin
      pending = 1'b0;
      if (s.fault) push_ev(CH_FAULT, t + 1, 128'({m_type, s.fault_vaddr}));
    end
    push_lvl(t, ~s.irq & idle, s.irq & s.mem_rdy & s.long_rdy & ~s.commit & idle & ~inflight, cnt);
    prev_miss = in_miss;
  endtask

  task automatic set_inputs(stim_t s);
    reset_i       = s.reset;
    v_i           = s.v;
    poison_i      = s.poison;
    sys_v_i       = s.sys;
    csr_v_i       = s.csr;
    is_store_i    = s.store;
    csr_imm_i     = s.csr_imm;
    pc_i          = s.pc;
    instr_i       = s.instr;
    rs1_i         = s.rs1;
    imm_i         = s.imm;
    csr_op_i      = s.op;
    flush_i       = s.flush;
    commit_v_i    = s.commit;
    itlb_miss_i   = s.itlb;
    dtlb_miss_i   = s.dtlb;
    irq_pending_i = s.irq;
    mem_ready_i   = s.mem_rdy;
    long_ready_i  = s.long_rdy;
    ptw_if.ptw_fill_v_i      = s.fill;
    ptw_if.ptw_fault_i       = s.fault;
    ptw_if.ptw_fault_vaddr_i = s.fault_vaddr;
  endtask

  task automatic drive(stim_t s);
    @(posedge clk);
    #1;
    cyc++;
    set_inputs(s);
    model(s);
  endtask

  task automatic mon(int ch, string nm, logic dv, logic [127:0] dd, bit has_data);
    ev_t e;
    bit  exp_v;
    exp_v = (q[ch].size() > 0) && (q[ch][0].t == cyc);
    check({nm, "_valid"}, 128'(dv), 128'(exp_v));
    if (exp_v) begin
      e = q[ch].pop_front();
      if (dv && has_data) check({nm, "_payload"}, dd, e.data);
    end
  endtask

  always @(negedge clk) begin
    lvl_t l;
    if (started) begin
      mon(CH_V,      "v_o",      v_o,                  '0, 1'b0);
      mon(CH_CSR,    "csr_cmd",  csr_cmd_v_o,          128'({csr_op_o, csr_addr_o, csr_data_o}), 1'b1);
      mon(CH_MISS,   "ptw_miss", ptw_if.ptw_miss_v_o,
          128'({ptw_if.ptw_miss_type_o, ptw_if.ptw_miss_pc_o, ptw_if.ptw_miss_vaddr_o}), 1'b1);
      mon(CH_FAULT,  "fault",    fault_v_o,            128'({fault_type_o, fault_vaddr_o}), 1'b1);
      mon(CH_REPLAY, "replay",   replay_o,             '0, 1'b0);
      if (q_lvl.size() > 0 && q_lvl[0].t == cyc) begin
        l = q_lvl.pop_front();
        check("ready_o",       128'(ready_o),       128'(l.ready));
        check("interrupt_v_o", 128'(interrupt_v_o), 128'(l.intr));
        check("miss_cnt_o",    128'(miss_cnt_o),    128'(l.cnt));
      end
    end
  end

  initial begin
    stim_t s;
    s = idle_stim();
    s.reset = 1'b1;
    set_inputs(s);
    started = 1'b1;
    repeat (3) drive(s);

    // Sys op reaches v_o after ST cycles; the same op followed by a flush never appears.
    s = idle_stim(); s.v = 1'b1; s.sys = 1'b1; drive(s);
    repeat (3) drive(idle_stim());
    s = idle_stim(); s.v = 1'b1; s.sys = 1'b1; drive(s);
    s = idle_stim(); s.flush = 1'b1; drive(s);
    repeat (3) drive(idle_stim());

    // csrrsi mstatus with uimm 5: committed once, then withheld without commit_v_i.
    for (int k = 0; k < 2; k++) begin
      s = idle_stim(); s.v = 1'b1; s.sys = 1'b1; s.csr = 1'b1; s.csr_imm = 1'b1;
      s.imm = 64'd5; s.rs1 = 64'hFF; s.instr = 32'h3002_E073; s.op = 4'h6;
      drive(s);
      drive(idle_stim());
      s = idle_stim(); s.commit = (k == 0); drive(s);
      drive(idle_stim());
    end

    // Store dtlb miss, a second miss during the walk, then a faulting fill.
    s = idle_stim(); s.v = 1'b1; s.sys = 1'b1; s.store = 1'b1;
    s.rs1 = 64'h1000; s.imm = 64'h8; s.pc = 39'h4000; drive(s);
    drive(idle_stim());
    s = idle_stim(); s.commit = 1'b1; s.dtlb = 1'b1; drive(s);
    repeat (3) drive(idle_stim());
    s = idle_stim(); s.commit = 1'b1; s.itlb = 1'b1; drive(s);
    s = idle_stim(); s.fill = 1'b1; s.fault = 1'b1; s.fault_vaddr = 39'h1008; drive(s);
    repeat (2) drive(idle_stim());

    // Interrupt taken only when nothing commits.
    s = idle_stim(); s.irq = 1'b1; drive(s);
    s.commit = 1'b1; drive(s);
    drive(idle_stim());

    // Three clean walks, then reset in the middle of a fourth and a stray fill afterwards.
    repeat (3) begin
      s = idle_stim(); s.commit = 1'b1; s.itlb = 1'b1; drive(s);
      repeat (2) drive(idle_stim());
      s = idle_stim(); s.fill = 1'b1; drive(s);
      drive(idle_stim());
    end
    s = idle_stim(); s.commit = 1'b1; s.dtlb = 1'b1; drive(s);
    repeat (2) drive(idle_stim());
    s = idle_stim(); s.reset = 1'b1; drive(s); drive(s);
    s = idle_stim(); s.fill = 1'b1; s.fault = 1'b1; s.fault_vaddr = 39'h7777; drive(s);
    repeat (2) drive(idle_stim());

    repeat (1500) drive(rand_stim());
    repeat (8) drive(idle_stim());

    @(negedge clk);
    #1;
    for (int ch = 0; ch < NCH; ch++) check($sformatf("queue%0d_drained", ch), 128'(q[ch].size()), '0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
